spram_mux32: RTL and testbench

Parametrised 32-bit single-port SRAM controller: the next-generation replacement for the fixed-width 8/16/32-bit SPRAM wrappers. It builds a memory from BANKS depth-cascaded pairs of SP256K primitives and serves byte, halfword and word accesses through one req/rdy port. Read data is lane-aligned and optionally sign-extended. After reset it runs an optional zero-fill sequence. It sits between the eForth core bus and the UP5K SPRAM macros.

---
 rtl/spram_mux32.sv | 125 ++++++++++++
 tb/tb_spram_mux32.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spram_mux32.sv
// spram_mux32: banked SP256K byte/half/word controller with lane-aligned,
// optionally sign-extended reads and a post-reset zero-fill.
module spram_mux32_sp256k (
  input  logic        clk,
  input  logic [13:0] ad,
  input  logic [15:0] di,
  input  logic [3:0]  mw,
  input  logic        we,
  input  logic        cs,
  output logic [15:0] dout
);
  logic [15:0] m [16384];
  always_ff @(posedge clk)
    if (cs) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (mw[i]) m[ad][4*i +: 4] <= di[4*i +: 4];
      end else dout <= m[ad];
    end
endmodule

module spram_mux32 #(
  parameter int BANKS = 2,
  parameter bit CLEAR = 1,
  parameter int AW    = 16 + $clog2(BANKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    sz,
  input  logic          sx,
  input  logic [AW-1:0] ai,
  input  logic [31:0]   vi,
  output logic          rdy,
  output logic [31:0]   vo,
  output logic          vld,
  output logic          err,
  output logic          busy
);
  localparam int BW = BANKS > 1 ? $clog2(BANKS) : 1;
  typedef enum logic {CLR, RUN} state_t;
  state_t state, state_nxt;
  logic [13:0] cnt, cnt_nxt;
  logic clr, acc, bad, ok, pend, r_sx;
  logic [1:0] r_sz, r_lane;
  logic [BW-1:0] bk, r_bank;
  logic [3:0] lm;
  logic [31:0] wd, rd, sh, fmt;
  logic [13:0] wa;
  logic [31:0] dout [BANKS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR ? CLR : RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == CLR) begin
      cnt_nxt   = &cnt ? cnt : cnt + 14'd1;
      state_nxt = &cnt ? RUN : CLR;
    end
  end
  assign clr  = state == CLR;
  assign rdy  = ~clr;
  assign busy = clr;
  assign acc  = req & rdy;
  assign bad  = (&sz) | (sz == 2'd1 & ai[0]) | (sz == 2'd2 & |ai[1:0]);
  assign ok   = acc & ~bad;
  assign lm = clr ? 4'hf : sz == 2'd0 ? 4'b0001 << ai[1:0] :
              sz == 2'd1 ? (ai[1] ? 4'b1100 : 4'b0011) : 4'hf;
  assign wd = clr ? 32'h0 : sz == 2'd0 ? {4{vi[7:0]}} :
              sz == 2'd1 ? {2{vi[15:0]}} : vi;
  assign wa = clr ? cnt : ai[15:2];
  generate
    if (BANKS > 1) begin : g_bk
      assign bk = ai[AW-1:16];
    end else begin : g_nbk
      assign bk = '0;
    end
  endgenerate
  // During the fill every pair is selected so all banks clear in parallel.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic cs;
    assign cs = clr | (ok & bk == BW'(b));
    spram_mux32_sp256k u_lo (
      .clk(clk), .ad(wa), .di(wd[15:0]), .mw({lm[1], lm[1], lm[0], lm[0]}),
      .we(clr | we), .cs(cs), .dout(dout[b][15:0])
    );
    spram_mux32_sp256k u_hi (
      .clk(clk), .ad(wa), .di(wd[31:16]), .mw({lm[3], lm[3], lm[2], lm[2]}),
      .we(clr | we), .cs(cs), .dout(dout[b][31:16])
    );
  end
  assign rd  = dout[r_bank];
  assign sh  = rd >> {r_lane, 3'b000};
  assign fmt = r_sz == 2'd0 ? {{24{r_sx & sh[7]}}, sh[7:0]} :
               r_sz == 2'd1 ? {{16{r_sx & sh[15]}}, sh[15:0]} : rd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend   <= 1'b0;
      vld    <= 1'b0;
      err    <= 1'b0;
      vo     <= 32'h0;
      r_sz   <= '0;
      r_sx   <= 1'b0;
      r_lane <= '0;
      r_bank <= '0;
    end else begin
      pend <= ok & ~we;
      err  <= acc & bad;
      vld  <= pend;
      if (pend) vo <= fmt;
      if (ok & ~we) begin
        r_sz   <= sz;
        r_sx   <= sx;
        r_lane <= ai[1:0];
        r_bank <= bk;
      end
    end
endmodule

// File: tb/tb_spram_mux32.sv
// tb_spram_mux32: byte-array reference model plus directed vectors for the
// 2-bank, clear-on-reset configuration.
module tb_spram_mux32;
  logic clk = 0, rst_n, req, we, sx, rdy, vld, err, busy;
  logic [1:0] sz;
  logic [16:0] ai;
  logic [31:0] vi, vo;
  int checks = 0, failures = 0;

  spram_mux32 #(.BANKS(2), .CLEAR(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .sz(sz), .sx(sx), .ai(ai),
    .vi(vi), .rdy(rdy), .vo(vo), .vld(vld), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 100) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, a one-deep pending read and a fill countdown.
  logic [7:0] mm [131072];
  int m_left;
  logic m_vld, m_err, m_pv;
  logic [31:0] m_vo, m_pd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 16384; m_vld = 0; m_err = 0; m_vo = 0; m_pv = 0;
    end else begin
      int a, n;
      logic [31:0] v;
      m_vld = m_pv;
      if (m_pv) m_vo = m_pd;
      m_pv = 0;
      m_err = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) foreach (mm[i]) mm[i] = 8'h0;
      end else if (req) begin
        a = int'(ai);
        n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
        if (sz == 3 || a % n != 0) m_err = 1;
        else if (we) begin
          for (int i = 0; i < n; i++) mm[a+i] = 8'((vi >> (8*i)) & 32'hff);
        end else begin
          v = 0;
          for (int i = 0; i < n; i++) v |= 32'(mm[a+i]) << (8*i);
          if (sx && n < 4 && ((v >> (8*n-1)) & 1) != 0) v |= 32'hffffffff << (8*n);
          m_pv = 1;
          m_pd = v;
        end
      end
    end
  end

  always @(negedge clk)
    if (rst_n) begin
      check("rdy", {31'b0, rdy}, {31'b0, m_left == 0});
      check("busy", {31'b0, busy}, {31'b0, m_left != 0});
      check("vld", {31'b0, vld}, {31'b0, m_vld});
      check("err", {31'b0, err}, {31'b0, m_err});
      check("vo", vo, m_vo);
    end

  task automatic drive(input logic w, input logic [1:0] s, input logic x,
                       input logic [16:0] a, input logic [31:0] v);
    req = 1; we = w; sz = s; sx = x; ai = a; vi = v;
  endtask

  task automatic acc(input logic w, input logic [1:0] s, input logic x,
                     input logic [16:0] a, input logic [31:0] v);
    @(negedge clk); drive(w, s, x, a, v);
    @(negedge clk); req = 0;
  endtask

  task automatic wr(input logic [16:0] a, input logic [1:0] s, input logic [31:0] v);
    acc(1, s, 0, a, v);
  endtask

  task automatic rd(input string name, input logic [16:0] a, input logic [1:0] s,
                    input logic x, input logic [31:0] exp);
    acc(0, s, x, a, 0);
    check({name, "_err"}, {31'b0, err}, 32'h0);
    @(negedge clk);
    check({name, "_vld"}, {31'b0, vld}, 32'h1);
    check(name, vo, exp);
  endtask

  logic [16:0] ba [4] = '{17'h00100, 17'h10200, 17'h00300, 17'h1fffc};
  logic [31:0] bd [4] = '{32'h12abbeef, 32'hcafef00d, 32'h0badbeef, 32'h11223344};
  int n;

  initial begin
    rst_n = 0; req = 0; we = 0; sz = 0; sx = 0; ai = 0; vi = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_rdy", {31'b0, rdy}, 32'h0);
    check("rst_vld", {31'b0, vld}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_vo", vo, 32'h0);
    rst_n = 1;
    repeat (5000) @(negedge clk);
    check("midfill_busy", {31'b0, busy}, 32'h1);
    drive(0, 2, 0, 17'h100, 0);
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      @(negedge clk); #1;
      check("fill_err", {31'b0, err}, 32'h0);
    end
    check("fill_len", n, 16384);
    req = 0;
    rd("rd_1fffc", 17'h1fffc, 2, 0, 32'h0);
    wr(17'h100, 2, 32'h12345678);
    rd("rb_100", 17'h100, 0, 0, 32'h78);
    rd("rb_101", 17'h101, 0, 0, 32'h56);
    rd("rb_102", 17'h102, 0, 0, 32'h34);
    rd("rb_103", 17'h103, 0, 0, 32'h12);
    wr(17'h203, 0, 32'h80);
    rd("rb_sx", 17'h203, 0, 1, 32'hffffff80);
    rd("rb_zx", 17'h203, 0, 0, 32'h80);
    wr(17'h102, 0, 32'hab);
    rd("rw_byte", 17'h100, 2, 0, 32'h12ab5678);
    wr(17'h100, 1, 32'hbeef);
    rd("rw_half", 17'h100, 2, 0, 32'h12abbeef);
    rd("rh_hi", 17'h102, 1, 1, 32'h000012ab);
    rd("rh_sx", 17'h100, 1, 1, 32'hffffbeef);
    rd("rw_sx_ign", 17'h100, 2, 1, 32'h12abbeef);
    acc(0, 1, 0, 17'h101, 0);
    check("mis_half_err", {31'b0, err}, 32'h1);
    check("mis_half_vld", {31'b0, vld}, 32'h0);
    @(negedge clk);
    check("mis_half_vld2", {31'b0, vld}, 32'h0);
    check("mis_half_err2", {31'b0, err}, 32'h0);
    acc(0, 3, 0, 17'h100, 0);
    check("sz3_err", {31'b0, err}, 32'h1);
    acc(1, 2, 0, 17'h102, 32'hdeadbeef);
    check("mis_word_err", {31'b0, err}, 32'h1);
    rd("unchanged", 17'h100, 2, 0, 32'h12abbeef);
    @(negedge clk); drive(1, 2, 0, 17'h304, 32'h55aa55aa);
    @(negedge clk); drive(0, 2, 0, 17'h304, 0);
    @(negedge clk); req = 0;
    @(negedge clk);
    check("raw", vo, 32'h55aa55aa);
    @(negedge clk); drive(0, 2, 0, 17'h304, 0);
    @(negedge clk); drive(1, 2, 0, 17'h304, 32'h11111111);
    @(negedge clk); req = 0;
    check("war_vld", {31'b0, vld}, 32'h1);
    check("war", vo, 32'h55aa55aa);
    wr(17'h10200, 2, 32'hcafef00d);
    wr(17'h300, 2, 32'h0badbeef);
    wr(17'h1fffc, 2, 32'h11223344);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) drive(0, 2, 0, ba[i], 0); else req = 0;
      if (i >= 2) begin
        check("b2b_vld", {31'b0, vld}, 32'h1);
        check("b2b", vo, bd[i-2]);
      end
    end
    @(negedge clk); drive(0, 2, 0, 17'h100, 0);
    @(negedge clk); req = 0;
    rst_n = 0;
    #1;
    check("cancel_vld", {31'b0, vld}, 32'h0);
    @(negedge clk);
    check("cancel_vld2", {31'b0, vld}, 32'h0);
    check("cancel_busy", {31'b0, busy}, 32'h1);
    rst_n = 1;
    repeat (4) @(negedge clk);
    check("refill_vld", {31'b0, vld}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
